// File: rtl/pwm_multi_ctrl_if.sv
// Bundles the button inputs, channel select and the PWM/LED outputs of
// pwm_multi_ctrl. The controller uses the slave modport. The environment
// that drives the buttons and observes the outputs uses the master modport.
interface pwm_multi_ctrl_if #(
  parameter int CHANNELS = 4
);
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                btn_incrPWM;
  logic                btn_decrPWM;
  logic [SEL_W-1:0]    ch_sel;
  logic [CHANNELS-1:0] pwm_out;
  logic                inled;
  logic                deled;
  logic                clock_1hz;

  modport master (
    output btn_incrPWM,
    output btn_decrPWM,
    output ch_sel,
    input  pwm_out,
    input  inled,
    input  deled,
    input  clock_1hz
  );

  modport slave (
    input  btn_incrPWM,
    input  btn_decrPWM,
    input  ch_sel,
    output pwm_out,
    output inled,
    output deled,
    output clock_1hz
  );
endinterface

// File: rtl/pwm_multi_ctrl.sv
// Multi-channel PWM controller.
// - Several duty registers share one free-running period counter.
// - Two debounced buttons step the shadow duty of the channel picked by ch_sel.
// - Shadow duties move into the active registers only at the period wrap, so
//   each period is always produced with one consistent duty.
// - Also provides a heartbeat square wave and the debounced button levels.
// Optional build macro PWM_PHASE_STAGGER_EN: channel i compares against the
// counter advanced by i*(2^DUTY_W/CHANNELS). This spreads the rising edges
// of the channels across the period.
module pwm_multi_ctrl #(
  parameter int CHANNELS        = 4,
  parameter int DUTY_W          = 8,
  parameter int STEP            = 16,
  parameter int RESET_DUTY      = 0,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CLK_HZ          = 10000
) (
  input logic              clk,
  input logic              reset,
  pwm_multi_ctrl_if.slave  bus
);

  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HALF  = ((CLK_HZ / 2) > 0) ? (CLK_HZ / 2) : 1;
  localparam int HB_W  = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [DUTY_W-1:0] DUTY_MAX   = {DUTY_W{1'b1}};
  localparam logic [DUTY_W:0]   DUTY_MAX_X = {1'b0, DUTY_MAX};
  localparam logic [DUTY_W:0]   STEP_X     = (DUTY_W + 1)'(STEP);
  localparam logic [DUTY_W-1:0] DUTY_RST   = DUTY_W'(RESET_DUTY);
  localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HB_W-1:0]   HB_LAST    = HB_W'(HALF - 1);

  // Increment clamps at full scale; the sum is formed one bit wider so it cannot wrap.
  function automatic logic [DUTY_W-1:0] sat_inc(input logic [DUTY_W-1:0] d);
    logic [DUTY_W:0] sum;
    sum = {1'b0, d} + STEP_X;
    if (sum > DUTY_MAX_X) begin
      return DUTY_MAX;
    end else begin
      return sum[DUTY_W-1:0];
    end
  endfunction

  // Decrement clamps at zero; a borrow shows up in the extra top bit.
  function automatic logic [DUTY_W-1:0] sat_dec(input logic [DUTY_W-1:0] d);
    logic [DUTY_W:0] diff;
    diff = {1'b0, d} - STEP_X;
    if (diff[DUTY_W]) begin
      return {DUTY_W{1'b0}};
    end else begin
      return diff[DUTY_W-1:0];
    end
  endfunction

  // Bit 0 = increment button, bit 1 = decrement button.
  logic [1:0]        btn_raw_s;
  logic [1:0]        sync1_r;
  logic [1:0]        sync2_r;
  logic [1:0]        level_r;
  logic [1:0]        level_d_r;
  logic [DB_W-1:0]   db_cnt_r [2];
  logic              inc_step_s;
  logic              dec_step_s;

  logic [DUTY_W-1:0] cnt_r;
  logic [DUTY_W-1:0] shadow_r     [CHANNELS];
  logic [DUTY_W-1:0] shadow_nxt_s [CHANNELS];
  logic [DUTY_W-1:0] active_r     [CHANNELS];
  logic [DUTY_W-1:0] cmp_cnt_s    [CHANNELS];
  logic [CHANNELS-1:0] pwm_cmp_s;
  logic [CHANNELS-1:0] pwm_r;

  logic [HB_W-1:0]   hb_cnt_r;
  logic              hb_r;

  assign btn_raw_s = {bus.btn_decrPWM, bus.btn_incrPWM};

  // Two-stage synchronisers, then a debounce counter per button that must see a stable changed level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r   <= 2'b00;
      sync2_r   <= 2'b00;
      level_r   <= 2'b00;
      level_d_r <= 2'b00;
      for (int b = 0; b < 2; b++) begin
        db_cnt_r[b] <= {DB_W{1'b0}};
      end
    end else begin
      sync1_r   <= btn_raw_s;
      sync2_r   <= sync1_r;
      level_d_r <= level_r;
      for (int b = 0; b < 2; b++) begin
        if (sync2_r[b] != level_r[b]) begin
          if (db_cnt_r[b] == DB_LAST) begin
            level_r[b]  <= sync2_r[b];
            db_cnt_r[b] <= {DB_W{1'b0}};
          end else begin
            db_cnt_r[b] <= db_cnt_r[b] + DB_W'(1);
          end
        end else begin
          db_cnt_r[b] <= {DB_W{1'b0}};
        end
      end
    end
  end

  // One-cycle step pulses on debounced rising edges; simultaneous presses cancel.
  always_comb begin
    inc_step_s = level_r[0] & ~level_d_r[0] & ~(level_r[1] & ~level_d_r[1]);
    dec_step_s = level_r[1] & ~level_d_r[1] & ~(level_r[0] & ~level_d_r[0]);
  end

  // Next shadow duty: only the selected channel moves; out-of-range selects match nothing.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      shadow_nxt_s[i] = shadow_r[i];
      if (bus.ch_sel == SEL_W'(i)) begin
        if (inc_step_s) begin
          shadow_nxt_s[i] = sat_inc(shadow_r[i]);
        end else if (dec_step_s) begin
          shadow_nxt_s[i] = sat_dec(shadow_r[i]);
        end else begin
          shadow_nxt_s[i] = shadow_r[i];
        end
      end else begin
        shadow_nxt_s[i] = shadow_r[i];
      end
    end
  end

  // Per-channel compare counter, optionally phase-shifted to stagger rising edges.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
`ifdef PWM_PHASE_STAGGER_EN
      cmp_cnt_s[i] = cnt_r + DUTY_W'(i * ((2 ** DUTY_W) / CHANNELS));
`else
      cmp_cnt_s[i] = cnt_r;
`endif
    end
  end

  // Compare: full-scale duty is forced high so it never drops out at the wrap.
  always_comb begin
    pwm_cmp_s = {CHANNELS{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      if (active_r[i] == DUTY_MAX) begin
        pwm_cmp_s[i] = 1'b1;
      end else begin
        pwm_cmp_s[i] = (cmp_cnt_s[i] < active_r[i]);
      end
    end
  end

  // Period counter, shadow/active duty registers with reload at the wrap, and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {DUTY_W{1'b0}};
      pwm_r <= {CHANNELS{1'b0}};
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_r[i] <= DUTY_RST;
        active_r[i] <= DUTY_RST;
      end
    end else begin
      cnt_r <= cnt_r + DUTY_W'(1);
      pwm_r <= pwm_cmp_s;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_r[i] <= shadow_nxt_s[i];
        if (cnt_r == DUTY_MAX) begin
          active_r[i] <= shadow_r[i];
        end else begin
          active_r[i] <= active_r[i];
        end
      end
    end
  end

  // Heartbeat divider: toggle once per half period of CLK_HZ cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      hb_cnt_r <= {HB_W{1'b0}};
      hb_r     <= 1'b0;
    end else if (hb_cnt_r == HB_LAST) begin
      hb_cnt_r <= {HB_W{1'b0}};
      hb_r     <= ~hb_r;
    end else begin
      hb_cnt_r <= hb_cnt_r + HB_W'(1);
      hb_r     <= hb_r;
    end
  end

  assign bus.pwm_out   = pwm_r;
  assign bus.inled     = level_r[0];
  assign bus.deled     = level_r[1];
  assign bus.clock_1hz = hb_r;

endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// Self-checking bench for pwm_multi_ctrl.
// A reference model reacts to every clock edge and queues the outputs it
// expects. A monitor pops that queue on the falling edge and compares it
// with the DUT. Directed scenarios add targeted checks, and a randomized
// phase follows them.
module tb_pwm_multi_ctrl;

  localparam int CH   = 2;
  localparam int DW   = 4;
  localparam int ST   = 4;
  localparam int RD   = 0;
  localparam int DB   = 3;
  localparam int HZ   = 20;
  localparam int P    = 2 ** DW;
  localparam int HALF = HZ / 2;

  typedef struct packed {
    logic [CH-1:0] pwm;
    logic          inl;
    logic          del;
    logic          hz;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   started  = 1'b0;

  pwm_multi_ctrl_if #(.CHANNELS(CH)) bus ();

  pwm_multi_ctrl #(
    .CHANNELS(CH), .DUTY_W(DW), .STEP(ST), .RESET_DUTY(RD),
    .DEBOUNCE_CYCLES(DB), .CLK_HZ(HZ)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic int phase_off(input int i);
`ifdef PWM_PHASE_STAGGER_EN
    return (i * (P / CH)) % P;
`else
    return 0 * i;
`endif
  endfunction

  // Reference model: duties as plain integers, time as edges since reset.
  initial begin : model
    int   t;
    int   shadow[CH];
    int   active[CH];
    int   new_act[CH];
    bit   lvl[2];
    bit   pend[2];
    int   run[2];
    bit   r1[2];
    bit   r2[2];
    bit   raw[2];
    bit   seen;
    int   cnt;
    int   c;
    int   sel;
    exp_t e;
    forever begin
      @(posedge clk);
      e = '0;
      if (reset) begin
        t = 0;
        for (int i = 0; i < CH; i++) begin
          shadow[i] = RD;
          active[i] = RD;
        end
        for (int b = 0; b < 2; b++) begin
          lvl[b] = 0; pend[b] = 0; run[b] = 0; r1[b] = 0; r2[b] = 0;
        end
      end else begin
        cnt = t % P;
        for (int i = 0; i < CH; i++) begin
          c = (cnt + phase_off(i)) % P;
          e.pwm[i] = (active[i] == P - 1) || (c < active[i]);
          new_act[i] = (cnt == P - 1) ? shadow[i] : active[i];
        end
        sel = int'(bus.ch_sel);
        if (sel < CH && pend[0] && !pend[1]) begin
          shadow[sel] = (shadow[sel] + ST > P - 1) ? P - 1 : shadow[sel] + ST;
        end else if (sel < CH && pend[1] && !pend[0]) begin
          shadow[sel] = (shadow[sel] - ST < 0) ? 0 : shadow[sel] - ST;
        end
        for (int i = 0; i < CH; i++) active[i] = new_act[i];
        raw[0] = bus.btn_incrPWM;
        raw[1] = bus.btn_decrPWM;
        for (int b = 0; b < 2; b++) begin
          // Level seen after two synchroniser stages: the raw value two edges back.
          seen    = (t >= 2) ? r2[b] : 1'b0;
          pend[b] = 1'b0;
          if (seen != lvl[b]) begin
            run[b]++;
            if (run[b] == DB) begin
              lvl[b]  = seen;
              run[b]  = 0;
              pend[b] = seen;
            end
          end else begin
            run[b] = 0;
          end
          r2[b] = r1[b];
          r1[b] = raw[b];
        end
        e.inl = lvl[0];
        e.del = lvl[1];
        e.hz  = ((t + 1) / HALF) % 2 == 1;
        t++;
      end
      exp_q.push_back(e);
      started = 1'b1;
    end
  end

  // Monitor: compare the DUT outputs with the oldest queued expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        if (started) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard_empty at %0t", $time);
        end
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        if (bus.pwm_out !== e.pwm || bus.inled !== e.inl ||
            bus.deled !== e.del || bus.clock_1hz !== e.hz) begin
          n_fail++;
          $display("FAIL scoreboard at %0t: got pwm=%b in=%b de=%b hz=%b, expected pwm=%b in=%b de=%b hz=%b",
                   $time, bus.pwm_out, bus.inled, bus.deled, bus.clock_1hz,
                   e.pwm, e.inl, e.del, e.hz);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit inc, input bit dec, input int hold, input int gap);
    bus.btn_incrPWM = inc;
    bus.btn_decrPWM = dec;
    tick(hold);
    bus.btn_incrPWM = 1'b0;
    bus.btn_decrPWM = 1'b0;
    tick(gap);
  endtask

  task automatic count_high(input int ch, input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      cnt += int'(bus.pwm_out[ch]);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stimulus
    int  lat;
    int  cnt;
    int  gap_len;
    bit  any;
    bit  hz0;
    reset           = 1'b1;
    bus.btn_incrPWM = 1'b0;
    bus.btn_decrPWM = 1'b0;
    bus.ch_sel      = 1'b0;
    tick(3);
    check("reset_pwm", int'(bus.pwm_out), 0);
    check("reset_leds", int'({bus.inled, bus.deled, bus.clock_1hz}), 0);
    reset = 1'b0;
    any = 1'b0;
    repeat (32) begin
      @(negedge clk);
      any |= |bus.pwm_out;
    end
    check("post_reset_pwm_low", int'(any), 0);

    // Clean increment on channel 1.
    bus.ch_sel      = 1'b1;
    bus.btn_incrPWM = 1'b1;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.inled && lat == 0) lat = k;
    end
    bus.btn_incrPWM = 1'b0;
    check("inled_latency", lat, 5);
    tick(40);
    count_high(1, 16, cnt);
    check("ch1_duty_after_inc", cnt, 4);
    count_high(0, 16, cnt);
    check("ch0_untouched", cnt, 0);

    // Bouncing increment never reaches the debounce threshold.
    any = 1'b0;
    for (int k = 0; k < 10; k++) begin
      bus.btn_incrPWM = ~bus.btn_incrPWM;
      repeat (2) begin
        @(negedge clk);
        any |= bus.inled;
      end
    end
    bus.btn_incrPWM = 1'b0;
    repeat (8) begin
      @(negedge clk);
      any |= bus.inled;
    end
    check("bounce_no_inled", int'(any), 0);
    tick(32);
    count_high(1, 16, cnt);
    check("bounce_duty_kept", cnt, 4);

    // Saturation at both ends on channel 0.
    bus.ch_sel = 1'b0;
    repeat (5) press(1'b1, 1'b0, 8, 8);
    tick(40);
    count_high(0, 32, cnt);
    check("ch0_saturated_high", cnt, 32);
    repeat (6) press(1'b0, 1'b1, 8, 8);
    tick(40);
    count_high(0, 32, cnt);
    check("ch0_saturated_low", cnt, 0);

    // Both buttons together cancel; then one more step on channel 1.
    bus.ch_sel = 1'b1;
    press(1'b1, 1'b1, 8, 8);
    tick(40);
    count_high(1, 16, cnt);
    check("simultaneous_no_change", cnt, 4);
    press(1'b1, 1'b0, 8, 8);
    tick(40);
    count_high(1, 16, cnt);
    check("ch1_second_step", cnt, 8);

    // Heartbeat: half period of HALF cycles.
    hz0 = bus.clock_1hz;
    for (int k = 0; k < 30 && bus.clock_1hz == hz0; k++) @(negedge clk);
    hz0 = bus.clock_1hz;
    gap_len = 0;
    for (int k = 0; k < 30 && bus.clock_1hz == hz0; k++) begin
      @(negedge clk);
      gap_len++;
    end
    check("heartbeat_half_period", gap_len, HALF);

    // Randomized presses, bounces, channel selects and occasional resets.
    repeat (150) begin
      if ($urandom_range(0, 15) == 0) begin
        reset = 1'b1;
        tick($urandom_range(1, 2));
        reset = 1'b0;
      end
      bus.ch_sel = 1'($urandom_range(0, 1));
      press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(1, 8), $urandom_range(1, 8));
    end
    tick(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_multi_ctrl.md
Name: pwm_multi_ctrl

Overview:
Parametrised multi-channel PWM controller, the successor to the single-channel button PWM.
- N independent duty registers share one free-running period counter.
- Debounced increment/decrement buttons step the duty of the channel picked by ch_sel.
- Duty changes take effect only at a period boundary, so outputs never glitch.
- A 1 Hz heartbeat and button-activity LEDs are kept.

Parameters:
CHANNELS, 4, number of PWM outputs (1..8)
DUTY_W, 8, duty/counter width; PWM period = 2^DUTY_W clocks
STEP, 16, duty change per accepted button press
RESET_DUTY, 0, duty loaded into every channel on reset
DEBOUNCE_CYCLES, 1000, consecutive stable cycles required to accept a button level
CLK_HZ, 10000, input clock frequency, used for clock_1hz

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
btn_incrPWM  input  1  raw increment button, asynchronous
btn_decrPWM  input  1  raw decrement button, asynchronous
ch_sel  input  max(1,$clog2(CHANNELS))  channel targeted by button steps
pwm_out  output  CHANNELS  registered PWM outputs, bit i = channel i
inled  output  1  debounced increment level
deled  output  1  debounced decrement level
clock_1hz  output  1  50% square wave, period CLK_HZ clocks

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high, sampled on the clk rising edge.
- Reset values:
  - pwm_out=0, inled=0, deled=0, clock_1hz=0
  - period counter=0, 1 Hz divider=0
  - all shadow and active duty registers = RESET_DUTY
  - synchronisers=0, debounce counters=0
- Reset mid-operation: aborts any pending step. A press still held after reset release must re-debounce before it is accepted.
- Button input path:
  - Each button passes through a 2-FF synchroniser.
  - The debounced level updates once the synchroniser output has differed from the current debounced level for DEBOUNCE_CYCLES consecutive cycles.
  - Any bounce back to the current level clears that button's counter.
- Step generation:
  - A rising edge of a debounced level generates one step pulse (one cycle).
  - Holding a button produces no repeat.
  - inled and deled equal the debounced levels.
- Step arithmetic:
  - Increment: shadow[ch_sel] = min(shadow + STEP, 2^DUTY_W-1).
  - Decrement: shadow[ch_sel] = max(shadow - STEP, 0).
  - Saturating, no wrap. Compute at DUTY_W+1 bits.
  - ch_sel is sampled in the step cycle.
  - ch_sel >= CHANNELS: the step is ignored.
- Simultaneous events: increment and decrement steps in the same cycle cancel, and no register changes.
- Shadow update latency: the shadow register updates on the clock edge after the step cycle.
- Period counter:
  - Counts 0..2^DUTY_W-1 every cycle and wraps.
  - In the cycle where counter == 2^DUTY_W-1, every active[i] <= shadow[i] at that edge, so the new duty starts with the period whose counter is 0.
- PWM compare: pwm_out[i] is registered, one cycle behind the compare.
  - Compare = (active[i] == 2^DUTY_W-1) ? 1 : (cnt < active[i]).
  - active = 0 gives constant low.
  - active = max gives constant high, with no dropout at wrap.
- Heartbeat divider:
  - Counts 0..CLK_HZ/2-1.
  - clock_1hz toggles on each wrap.
  - CLK_HZ odd: use floor(CLK_HZ/2).

Optional Feature:
PWM_PHASE_STAGGER_EN
- Defined: channel i compares against (cnt + i*(2^DUTY_W/CHANNELS)) mod 2^DUTY_W instead of cnt, so channel rising edges are spread across the period to reduce simultaneous switching.
  - Duty ratio per period is unchanged.
  - Active duty reload still happens at the shared cnt wrap.
- Undefined: all channels compare against cnt, and all rising edges align at cnt=0.

Test Plan:
All scenarios use CHANNELS=2, DUTY_W=4, STEP=4, RESET_DUTY=0, DEBOUNCE_CYCLES=3, CLK_HZ=20.
- Reset: hold reset 3 cycles. Required: pwm_out=00, inled=deled=clock_1hz=0, and pwm_out stays 00 for 32 cycles after release.
- Increment: ch_sel=1, press incr cleanly for 10 cycles. Required:
  - inled rises 5 cycles after the press (2 sync + 3 debounce).
  - Exactly one step; shadow[1]=4.
  - From the next period, pwm_out[1] is high for exactly 4 of every 16 cycles.
  - pwm_out[0] stays 0.
- Bounce: incr toggling every 2 cycles for 20 cycles, then released. Required: inled never rises and duty is unchanged.
- Saturation: 5 increments on ch 0 gives duty 15 and pwm_out[0] constant high. Then 6 decrements give duty 0 and pwm_out[0] constant low, with no wrap at either end.
- Simultaneous presses and period boundary:
  - Both buttons rise together: no duty change.
  - A step landing mid-period leaves the current period's high-time unchanged; the new value applies from the next cnt=0.
- Heartbeat: clock_1hz toggles every 10 cycles (period 20). With PWM_PHASE_STAGGER_EN defined, ch1 at duty 4 rises at cnt=8, not cnt=0.
